// File: rtl/bakraid_sdram_pkg.sv
// Shared types and constants for the Bakraid sound-side SDRAM arbitration.
package bakraid_sdram_pkg;

  localparam int PCM_AW   = 22;
  localparam int PCM_NREQ = 4;

  // Bank transaction FSM: pick a requester, hold BA_RD until accepted, wait for data.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/bakraid_rr_arbiter.sv
// N-way round-robin grant. The search starts at the pointer and wraps; the
// pointer moves to one past the granted index only when the grant is accepted.
module bakraid_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          accept_i,
  output logic          gnt_valid_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] ptr_q;
  int            j;

  // Walk from the farthest candidate down so the one closest to the pointer wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    j           = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_q) + k) % N;
      if (req_i[j]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IW'(j);
      end
    end
  end

  // Pointer advances past the accepted grant, wrapping at N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept_i && gnt_valid_o) begin
      ptr_q <= (int'(gnt_idx_o) == N - 1) ? '0 : gnt_idx_o + IW'(1);
    end
  end

endmodule

// File: rtl/bakraid_pcm_sdram_arbiter.sv
// Shares one SDRAM bank read port between the three YMZ PCM channels and the
// sound Z80 ROM fetch. Each requester owns one cached 16-bit word; misses are
// fetched one at a time in round-robin order.
// Optional feature: BAKRAID_PCM_CACHE_EN keeps entries valid while CS is low.
//
// Bank handshake: BA_RD is held high with a stable BA_ADDR from entry into
// ISSUE until the cycle BA_ACK is sampled high; it is never withdrawn early.
// DATA_READ is consumed only on a cycle with BA_RDY high while in WAIT, or in
// ISSUE together with BA_ACK; BA_RDY at any other time is ignored.
module bakraid_pcm_sdram_arbiter
  import bakraid_sdram_pkg::*;
#(
  parameter int          N_REQ     = PCM_NREQ,
  parameter int          AW        = PCM_AW,
  parameter logic [21:0] BANK_BASE = 22'h0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [N_REQ-1:0]    REQ_CS,
  input  logic [N_REQ*AW-1:0] REQ_ADDR,
  output logic [N_REQ-1:0]    REQ_OK,
  output logic [N_REQ*8-1:0]  REQ_DOUT,
  output logic [21:0]         BA_ADDR,
  output logic                BA_RD,
  input  logic                BA_ACK,
  input  logic                BA_RDY,
  input  logic [15:0]         DATA_READ,
  output state_e              dbg_state_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q, state_d;
  logic [IW-1:0]      gnt_q;
  logic [AW-2:0]      gaddr_q;
  logic [21:0]        ba_addr_q;

  logic [AW-2:0]      tag_q  [N_REQ];
  logic [15:0]        word_q [N_REQ];
  logic [N_REQ-1:0]   valid_q;

  logic [N_REQ-1:0]   hit;
  logic [N_REQ-1:0]   pending;
  logic               arb_valid;
  logic [IW-1:0]      arb_idx;
  logic [AW-2:0]      arb_word;
  logic               accept;
  logic               fill;

  // Hit detection and byte lane selection straight from the entry registers.
  always_comb begin
    hit      = '0;
    REQ_DOUT = '0;
    for (int i = 0; i < N_REQ; i++) begin
      hit[i] = REQ_CS[i] & valid_q[i] & (tag_q[i] == REQ_ADDR[i*AW+1 +: AW-1]);
      REQ_DOUT[i*8 +: 8] = REQ_ADDR[i*AW] ? word_q[i][15:8] : word_q[i][7:0];
    end
  end

  assign REQ_OK      = hit;
  assign pending     = REQ_CS & ~hit;
  assign BA_RD       = (state_q == ISSUE);
  assign BA_ADDR     = ba_addr_q;
  assign dbg_state_o = state_q;

  bakraid_rr_arbiter #(.N(N_REQ)) u_arb (
    .clk         (CLK),
    .rst         (RESET),
    .req_i       (pending),
    .accept_i    (accept),
    .gnt_valid_o (arb_valid),
    .gnt_idx_o   (arb_idx)
  );

  // Word address of whichever requester the arbiter currently offers.
  always_comb begin
    arb_word = REQ_ADDR[int'(arb_idx)*AW+1 +: AW-1];
  end

  // Next-state logic: accept a grant in IDLE, fill on data return.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    fill    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (BA_ACK) begin
          if (BA_RDY) begin
            fill    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (BA_RDY) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state plus the latched grant and its bank address.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gaddr_q   <= '0;
      ba_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gnt_q     <= arb_idx;
        gaddr_q   <= arb_word;
        ba_addr_q <= BANK_BASE + 22'(arb_word);
      end
    end
  end

  // Entry storage: fill the granted slot; validity depends on the cache option.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < N_REQ; i++) begin
        tag_q[i]  <= '0;
        word_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (fill && int'(gnt_q) == i) begin
          tag_q[i]  <= gaddr_q;
          word_q[i] <= DATA_READ;
        end
`ifdef BAKRAID_PCM_CACHE_EN
        if (fill && int'(gnt_q) == i) begin
          valid_q[i] <= 1'b1;
        end
`else
        if (!REQ_CS[i]) begin
          valid_q[i] <= 1'b0;
        end else if (fill && int'(gnt_q) == i) begin
          valid_q[i] <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_bakraid_pcm_sdram_arbiter.sv
// Directed bench for bakraid_pcm_sdram_arbiter. A second instance with
// BANK_BASE=22'h3FFFFF covers bank address wrap.
module tb_bakraid_pcm_sdram_arbiter;
  import bakraid_sdram_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;

  logic [3:0]  req_cs;
  logic [87:0] req_addr;
  logic [3:0]  req_ok;
  logic [31:0] req_dout;
  logic [21:0] ba_addr;
  logic        ba_rd;
  logic        ba_ack;
  logic        ba_rdy;
  logic [15:0] data_read;
  state_e      dbg_state;

  logic [3:0]  w_cs;
  logic [87:0] w_addr;
  logic [3:0]  w_ok;
  logic [31:0] w_dout;
  logic [21:0] w_ba_addr;
  logic        w_rd;
  logic        w_ack;
  logic        w_rdy;
  logic [15:0] w_data;
  state_e      w_state;

  int checks = 0;
  int passes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bakraid_pcm_sdram_arbiter dut (
    .CLK(clk), .RESET(rst), .REQ_CS(req_cs), .REQ_ADDR(req_addr),
    .REQ_OK(req_ok), .REQ_DOUT(req_dout), .BA_ADDR(ba_addr), .BA_RD(ba_rd),
    .BA_ACK(ba_ack), .BA_RDY(ba_rdy), .DATA_READ(data_read),
    .dbg_state_o(dbg_state)
  );

  bakraid_pcm_sdram_arbiter #(.BANK_BASE(22'h3FFFFF)) dut_wrap (
    .CLK(clk), .RESET(rst), .REQ_CS(w_cs), .REQ_ADDR(w_addr),
    .REQ_OK(w_ok), .REQ_DOUT(w_dout), .BA_ADDR(w_ba_addr), .BA_RD(w_rd),
    .BA_ACK(w_ack), .BA_RDY(w_rdy), .DATA_READ(w_data),
    .dbg_state_o(w_state)
  );

  // ---------------- driver tasks ----------------
  task automatic set_addr(input int i, input logic [21:0] a);
    req_addr[i*22 +: 22] = a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_cs    = '0;
    req_addr  = '0;
    ba_ack    = 1'b0;
    ba_rdy    = 1'b0;
    data_read = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for BA_RD at a negedge and capture the bank address.
  task automatic wait_rd(output logic [21:0] a, output bit seen);
    seen = 1'b0;
    a    = '0;
    for (int c = 0; c < 20; c++) begin
      if (ba_rd) begin
        seen = 1'b1;
        a    = ba_addr;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Bank model: accept the request, return data one cycle later. Returns at
  // the negedge following the fill edge.
  task automatic serve(input logic [15:0] d, output logic [21:0] a, output bit seen);
    wait_rd(a, seen);
    if (seen) begin
      ba_ack = 1'b1;
      @(negedge clk);
      ba_ack    = 1'b0;
      ba_rdy    = 1'b1;
      data_read = d;
      @(negedge clk);
      ba_rdy = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst       = 1'b1;
    req_cs    = '0;
    req_addr  = '0;
    ba_ack    = 1'b0;
    ba_rdy    = 1'b0;
    data_read = '0;
    w_cs = '0; w_addr = '0; w_ack = 1'b0; w_rdy = 1'b0; w_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (ba_rd !== 1'b0) $display("FAIL reset_ba_rd got=%b exp=0", ba_rd); else passes++;
    checks++; if (ba_addr !== 22'h0) $display("FAIL reset_ba_addr got=%h exp=0", ba_addr); else passes++;
    checks++; if (req_ok !== 4'h0) $display("FAIL reset_ok got=%h exp=0", req_ok); else passes++;
    checks++; if (req_dout !== 32'h0) $display("FAIL reset_dout got=%h exp=0", req_dout); else passes++;
    checks++; if (dbg_state !== IDLE) $display("FAIL reset_state got=%0d exp=IDLE", dbg_state); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_miss_hit();
    logic [21:0] a; bit seen; bit any_rd;
    do_reset();
    req_cs[0] = 1'b1;
    set_addr(0, 22'h000101);
    serve(16'hA55A, a, seen);
    checks++; if (!seen || a !== 22'h80) $display("FAIL miss_ba_addr got=%h seen=%b exp=000080", a, seen); else passes++;
    checks++; if (req_ok[0] !== 1'b1) $display("FAIL miss_ok got=%b exp=1", req_ok[0]); else passes++;
    checks++; if (req_dout[7:0] !== 8'hA5) $display("FAIL miss_dout_hi got=%h exp=a5", req_dout[7:0]); else passes++;
    set_addr(0, 22'h000100);
    #1;
    checks++; if (req_ok[0] !== 1'b1 || req_dout[7:0] !== 8'h5A)
      $display("FAIL hit_same_cycle ok=%b dout=%h exp ok=1 dout=5a", req_ok[0], req_dout[7:0]); else passes++;
    any_rd = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      any_rd |= ba_rd;
    end
    checks++; if (any_rd !== 1'b0) $display("FAIL hit_no_bank got=%b exp=0", any_rd); else passes++;
  endtask

  task automatic test_round_robin();
    logic [21:0] a; bit seen;
    logic [21:0] exp_a [5];
    exp_a[0] = 22'h100; exp_a[1] = 22'h200; exp_a[2] = 22'h300;
    exp_a[3] = 22'h400; exp_a[4] = 22'h500;
    do_reset();
    set_addr(0, 22'h200); set_addr(1, 22'h400);
    set_addr(2, 22'h600); set_addr(3, 22'h800);
    req_cs = 4'hF;
    for (int k = 0; k < 5; k++) begin
      serve(16'h1111 * 16'(k + 1), a, seen);
      checks++; if (!seen || a !== exp_a[k])
        $display("FAIL rr_grant%0d got=%h seen=%b exp=%h", k, a, seen, exp_a[k]); else passes++;
      if (k == 0) set_addr(0, 22'hA00);
    end
    checks++; if (req_ok !== 4'hF) $display("FAIL rr_all_ok got=%h exp=f", req_ok); else passes++;
    checks++; if (req_dout !== 32'h44_33_22_55)
      $display("FAIL rr_dout got=%h exp=44332255", req_dout); else passes++;
  endtask

  task automatic test_addr_change();
    logic [21:0] a; bit seen;
    do_reset();
    req_cs[2] = 1'b1;
    set_addr(2, 22'h10);
    wait_rd(a, seen);
    checks++; if (!seen || a !== 22'h8) $display("FAIL chg_first_addr got=%h seen=%b exp=000008", a, seen); else passes++;
    ba_ack = 1'b1;
    @(negedge clk);
    ba_ack = 1'b0;
    set_addr(2, 22'h20);
    ba_rdy    = 1'b1;
    data_read = 16'h1234;
    @(negedge clk);
    ba_rdy = 1'b0;
    checks++; if (req_ok[2] !== 1'b0) $display("FAIL chg_ok_low got=%b exp=0", req_ok[2]); else passes++;
    checks++; if (req_dout[23:16] !== 8'h34) $display("FAIL chg_old_entry got=%h exp=34", req_dout[23:16]); else passes++;
    serve(16'hBEEF, a, seen);
    checks++; if (!seen || a !== 22'h10) $display("FAIL chg_refetch_addr got=%h seen=%b exp=000010", a, seen); else passes++;
    checks++; if (req_ok[2] !== 1'b1 || req_dout[23:16] !== 8'hEF)
      $display("FAIL chg_final ok=%b dout=%h exp ok=1 dout=ef", req_ok[2], req_dout[23:16]); else passes++;
  endtask

  task automatic test_reset_in_wait();
    logic [21:0] a; bit seen;
    do_reset();
    req_cs[3] = 1'b1;
    set_addr(3, 22'h30);
    serve(16'h5566, a, seen);
    checks++; if (!seen || req_ok[3] !== 1'b1) $display("FAIL rw_pre_ok got=%b exp=1", req_ok[3]); else passes++;
    req_cs[1] = 1'b1;
    set_addr(1, 22'h40);
    wait_rd(a, seen);
    ba_ack = 1'b1;
    @(negedge clk);
    ba_ack = 1'b0;
    checks++; if (dbg_state !== WAIT) $display("FAIL rw_in_wait got=%0d exp=WAIT", dbg_state); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (ba_rd !== 1'b0 || req_ok !== 4'h0 || dbg_state !== IDLE)
      $display("FAIL rw_async rd=%b ok=%h st=%0d exp rd=0 ok=0 st=IDLE", ba_rd, req_ok, dbg_state); else passes++;
    @(negedge clk);
    rst = 1'b0;
    serve(16'h7788, a, seen);
    checks++; if (!seen || a !== 22'h20) $display("FAIL rw_refetch got=%h seen=%b exp=000020", a, seen); else passes++;
    checks++; if (req_ok[1] !== 1'b1 || req_dout[15:8] !== 8'h88)
      $display("FAIL rw_ok ok=%b dout=%h exp ok=1 dout=88", req_ok[1], req_dout[15:8]); else passes++;
  endtask

  task automatic test_cs_drop();
    logic [21:0] a; bit seen; bit any_rd;
    do_reset();
    req_cs[0] = 1'b1;
    set_addr(0, 22'h50);
    serve(16'hCAFE, a, seen);
    checks++; if (!seen || a !== 22'h28 || req_ok[0] !== 1'b1)
      $display("FAIL cs_first addr=%h ok=%b exp addr=000028 ok=1", a, req_ok[0]); else passes++;
    req_cs[0] = 1'b0;
    @(negedge clk);
    req_cs[0] = 1'b1;
    #1;
`ifdef BAKRAID_PCM_CACHE_EN
    checks++; if (req_ok[0] !== 1'b1) $display("FAIL cs_return_ok got=%b exp=1", req_ok[0]); else passes++;
    any_rd = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      any_rd |= ba_rd;
    end
    checks++; if (any_rd !== 1'b0) $display("FAIL cs_return_no_bank got=%b exp=0", any_rd); else passes++;
`else
    any_rd = 1'b0;
    checks++; if (req_ok[0] !== 1'b0) $display("FAIL cs_return_ok got=%b exp=0", req_ok[0]); else passes++;
    serve(16'hCAFE, a, seen);
    checks++; if (!seen || a !== 22'h28 || req_ok[0] !== 1'b1)
      $display("FAIL cs_refetch addr=%h seen=%b ok=%b exp addr=000028 ok=1", a, seen, req_ok[0]); else passes++;
`endif
    // Fill that lands while CS is low.
    set_addr(0, 22'h70);
    wait_rd(a, seen);
    ba_ack = 1'b1;
    @(negedge clk);
    ba_ack    = 1'b0;
    req_cs[0] = 1'b0;
    ba_rdy    = 1'b1;
    data_read = 16'h9A9B;
    @(negedge clk);
    ba_rdy    = 1'b0;
    req_cs[0] = 1'b1;
    #1;
`ifdef BAKRAID_PCM_CACHE_EN
    checks++; if (!seen || req_ok[0] !== 1'b1) $display("FAIL cs_low_fill_kept got=%b exp=1", req_ok[0]); else passes++;
`else
    checks++; if (!seen || req_ok[0] !== 1'b0) $display("FAIL cs_low_fill_discard got=%b exp=0", req_ok[0]); else passes++;
    serve(16'h9A9B, a, seen);
`endif
    req_cs = '0;
  endtask

  task automatic test_wrap_ack_rdy();
    bit seen;
    w_cs[0] = 1'b1;
    w_addr[21:0] = 22'h2;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (w_rd) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (!seen || w_ba_addr !== 22'h0) $display("FAIL wrap_addr got=%h seen=%b exp=000000", w_ba_addr, seen); else passes++;
    w_ack  = 1'b1;
    w_rdy  = 1'b1;
    w_data = 16'h0F0E;
    @(negedge clk);
    w_ack = 1'b0;
    w_rdy = 1'b0;
    checks++; if (w_state !== IDLE) $display("FAIL ackrdy_state got=%0d exp=IDLE", w_state); else passes++;
    checks++; if (w_ok[0] !== 1'b1 || w_dout[7:0] !== 8'h0E)
      $display("FAIL ackrdy_fill ok=%b dout=%h exp ok=1 dout=0e", w_ok[0], w_dout[7:0]); else passes++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_miss_hit();
    test_round_robin();
    test_addr_change();
    test_reset_in_wait();
    test_cs_drop();
    test_wrap_ack_rdy();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
